button_debouncer: RTL

//   Synchronizes a raw, bouncing push-button input into the clk domain and filters it

---
 rtl/button_debouncer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Purpose:
//   Takes a raw, bouncing push-button level from a board pin and brings it
//   into the clk domain through a flip-flop synchronizer. It then filters it
//   into a clean, registered level (dout) for the downstream edge-to-pulse
//   stage. A change of level is accepted only after the synchronized input
//   has held the new value long enough. That means one entry cycle followed
//   by CNT_MAX counted cycles.
//
// Parameters:
//   CNT_MAX      stable cycles required before accepting a change (>= 1)
//   SYNC_STAGES  depth of the input synchronizer chain (>= 2)
//
// Ports:
//   clk    in   system clock, all logic on the rising edge
//   rst_n  in   synchronous active-low reset
//   btn    in   raw asynchronous button level
//   dout   out  debounced level (registered)
//   rise   out  one-cycle strobe on dout 0->1 (edge build only, else 0)
//   fall   out  one-cycle strobe on dout 1->0 (edge build only, else 0)
//
// Build option:
//   DEBOUNCE_EDGE_EN  when defined, rise/fall are registered strobes that
//                     assert on the same edge dout updates. When undefined,
//                     both are tied low and no extra flops are built.
//
// Valid/ready:
//   This block has no handshake. btn is sampled on every edge and dout is a
//   level. In the edge build, rise/fall are single-cycle strobes that need no
//   acknowledge.
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int CNT_MAX     = 100_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int            CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    // State is kept as a named enum so checkers can bind to r_state directly.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   r_dout;
    logic                   w_dout_next;
    logic                   w_accept_hi;
    logic                   w_accept_lo;

    // ------------------------------------------------------------------
    // Input synchronizer: btn enters at bit 0. The FSM only ever looks at
    // the last stage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM process 1: state register (state, counter, debounced level)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_dout  <= w_dout_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state and counter.
    // A reversion of s during a pending state returns to the stable state
    // with the counter cleared. A partial count is therefore never carried
    // into the next attempt.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            STABLE_LO: begin
                if (w_s) begin
                    w_state_next = PEND_HI;
                    w_cnt_next   = '0;
                end
            end
            PEND_HI: begin
                if (!w_s) begin
                    w_state_next = STABLE_LO;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = STABLE_HI;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CW'(1);
                end
            end
            STABLE_HI: begin
                if (!w_s) begin
                    w_state_next = PEND_LO;
                    w_cnt_next   = '0;
                end
            end
            PEND_LO: begin
                if (w_s) begin
                    w_state_next = STABLE_HI;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = STABLE_LO;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = STABLE_LO;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: acceptance decode and next debounced level.
    // dout moves only on acceptance, which requires that s already held in
    // the pending state. It therefore never changes on the edge where s
    // itself changes.
    // ------------------------------------------------------------------
    always_comb begin
        w_accept_hi = (r_state == PEND_HI) && w_s  && (r_cnt == CNT_LAST);
        w_accept_lo = (r_state == PEND_LO) && !w_s && (r_cnt == CNT_LAST);
        w_dout_next = r_dout;
        if (w_accept_hi) begin
            w_dout_next = 1'b1;
        end else if (w_accept_lo) begin
            w_dout_next = 1'b0;
        end
    end

    assign dout = r_dout;

`ifdef DEBOUNCE_EDGE_EN
    // Strobes are registered from the same acceptance terms as dout, so they
    // line up with the dout update. The two pending states are mutually
    // exclusive, so rise and fall can never assert together.
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept_hi;
            r_fall <= w_accept_lo;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule
